// File: rtl/uart_defs.sv
// uart_defs: shared UART types, mode constants and the half-duplex state encoding.
package uart_defs;
    localparam logic [1:0] FULLDUPLEX = 2'd0;
    localparam logic [1:0] HALFDUPLEX = 2'd1;
    localparam logic [1:0] SIMPLEX    = 2'd2;

    typedef struct packed {
        logic [1:0] mode;
        logic       master;
    } Config_t;

    typedef enum logic [1:0] {
        HD_IDLE  = 2'd0,
        HD_TX    = 2'd1,
        HD_RX    = 2'd2,
        HD_GUARD = 2'd3
    } HdState_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: generic N-stage bit synchroniser with a selectable reset value.
module uart_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst)
        if (rst) sr <= {STAGES{RST_VAL}};
        else     sr <= {sr[STAGES-2:0], d};

    assign q = sr[STAGES-1];
endmodule

// File: rtl/uart_hw_flow_ctrl.sv
// uart_hw_flow_ctrl: RTS/CTS flow control with watermark hysteresis and a
// half-duplex line arbiter with turnaround guard time.
module uart_hw_flow_ctrl import uart_defs::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_AW     = 4,
    parameter int GUARD_W     = 8
) (
    input  logic               tck,
    input  logic               rst,
    input  logic               cts_n_i,
    output logic               rts_n_o,
    input  logic               tx_req_i,
    input  logic               tx_busy_i,
    output logic               tx_grant_o,
    output logic               tx_enable_o,
    input  logic               rx_busy_i,
    input  logic [FIFO_AW:0]   rx_level_i,
    output logic               rx_enable_o,
    input  logic               cfg_fc_en_i,
    input  logic [FIFO_AW:0]   cfg_hi_wm_i,
    input  logic [FIFO_AW:0]   cfg_lo_wm_i,
    input  logic [GUARD_W-1:0] cfg_guard_i,
    input  Config_t            uart_config_i,
    output logic [1:0]         hd_state_o
);
    HdState_t           state, next;
    logic               cts_s, rx_rdy, cts_ok, rts_fd, hd, master, mode_chg;
    logic               rts_n, tx_grant, tx_en, rx_en;
    logic [GUARD_W-1:0] cnt;
    logic [1:0]         mode_q;

    uart_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cts_sync (
        .clk(tck),
        .rst(rst),
        .d(cts_n_i),
        .q(cts_s)
    );

    assign hd       = uart_config_i.mode == HALFDUPLEX;
    assign master   = uart_config_i.master;
    assign cts_ok   = ~cts_s | ~cfg_fc_en_i;
    assign rts_fd   = cfg_fc_en_i & ~rx_rdy;
    assign mode_chg = (uart_config_i.mode != mode_q) && (state != HD_IDLE);

    always_comb begin
        next = state;
        if (mode_chg)
            next = HD_GUARD;
        else
            case (state)
                HD_IDLE:  next = !hd ? HD_IDLE :
                                 (~cts_s & ~(tx_req_i & master)) ? HD_RX :
                                 tx_req_i ? HD_TX : HD_IDLE;
                HD_TX:    next = (~tx_req_i & ~tx_busy_i) ? HD_GUARD : HD_TX;
                HD_RX:    next = (cts_s & ~rx_busy_i) ? HD_GUARD : HD_RX;
                default:  next = (cnt == '0) ? HD_IDLE : HD_GUARD;
            endcase
    end

    // Outputs are registered from the next state so they line up with hd_state_o.
    always_comb begin
        tx_en    = 1'b0;
        rx_en    = 1'b0;
        rts_n    = 1'b1;
        tx_grant = 1'b0;
        if (next == HD_TX) begin
            tx_en    = 1'b1;
            rts_n    = 1'b0;
            tx_grant = tx_req_i & cts_ok;
        end else if (next == HD_RX) begin
            rx_en = 1'b1;
            rts_n = ~rx_rdy;
        end else if (next == HD_IDLE && !hd) begin
            tx_en    = (uart_config_i.mode != SIMPLEX) | master;
            rx_en    = (uart_config_i.mode != SIMPLEX) | ~master;
            rts_n    = rx_en ? rts_fd : 1'b1;
            tx_grant = tx_en & tx_req_i & cts_ok;
        end
    end

    always_ff @(posedge tck or posedge rst)
        if (rst) begin
            state       <= HD_IDLE;
            cnt         <= '0;
            mode_q      <= FULLDUPLEX;
            rx_rdy      <= 1'b1;
            rts_n_o     <= 1'b1;
            tx_grant_o  <= 1'b0;
            tx_enable_o <= 1'b0;
            rx_enable_o <= 1'b0;
        end else begin
            state       <= next;
            mode_q      <= uart_config_i.mode;
            cnt         <= (next == HD_GUARD && state != HD_GUARD) ? cfg_guard_i :
                           (state == HD_GUARD && cnt != '0) ? cnt - GUARD_W'(1) : cnt;
            rx_rdy      <= (rx_level_i >= cfg_hi_wm_i) ? 1'b0 :
                           (rx_level_i <= cfg_lo_wm_i) ? 1'b1 : rx_rdy;
            rts_n_o     <= rts_n;
            tx_grant_o  <= tx_grant;
            tx_enable_o <= tx_en;
            rx_enable_o <= rx_en;
        end

    assign hd_state_o = state;
endmodule

// File: tb/tb_uart_hw_flow_ctrl.sv
// tb_uart_hw_flow_ctrl: vector table, hand-written corner sequences and a
// randomized full-duplex run against a history-based reference model.
module tb_uart_hw_flow_ctrl;
    import uart_defs::*;
    localparam int S = 2, AW = 4, GW = 8, HI = 12, LO = 4, N = 300;

    logic          tck = 0, rst = 0, cts_n = 1, tx_req = 0, tx_busy = 0, rx_busy = 0, fc_en = 1;
    logic          rts_n, tx_grant, tx_enable, rx_enable;
    logic [AW:0]   rx_level = '0, hi_wm = 5'(HI), lo_wm = 5'(LO);
    logic [GW-1:0] guard = '0;
    Config_t       cfg = '{mode: FULLDUPLEX, master: 1'b0};
    logic [1:0]    hd_state;
    int            checks = 0, errors = 0;

    always #5 tck = ~tck;

    uart_hw_flow_ctrl #(.SYNC_STAGES(S), .FIFO_AW(AW), .GUARD_W(GW)) dut (
        .tck(tck), .rst(rst), .cts_n_i(cts_n), .rts_n_o(rts_n),
        .tx_req_i(tx_req), .tx_busy_i(tx_busy), .tx_grant_o(tx_grant),
        .tx_enable_o(tx_enable), .rx_busy_i(rx_busy), .rx_level_i(rx_level),
        .rx_enable_o(rx_enable), .cfg_fc_en_i(fc_en), .cfg_hi_wm_i(hi_wm),
        .cfg_lo_wm_i(lo_wm), .cfg_guard_i(guard), .uart_config_i(cfg),
        .hd_state_o(hd_state)
    );

    typedef struct {
        logic [1:0]  mode;
        logic        master, fc, cts, req;
        logic [AW:0] lvl;
        logic [5:0]  exp;
    } vec_t;
    vec_t tv [11];

    bit          cts_h [N], req_h [N], fc_h [N];
    logic [AW:0] lvl_h [N];

    task automatic tick;
        @(posedge tck);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {tx_enable, rx_enable, rts_n, tx_grant, hd_state};
    endfunction

    task automatic wait_state(input string name, input logic [1:0] s, input int bound);
        int n = 0;
        while (hd_state != s && n < bound) begin
            tick;
            n++;
        end
        check(name, int'(hd_state), int'(s));
    endtask

    task automatic guard_run(input int g);
        int n = 0, gc = 0;
        guard  = GW'(g);
        tx_req = 0;
        do begin
            tick;
            n++;
            if (hd_state == 2'd3) begin
                gc++;
                check($sformatf("guard%0d_outs", g), int'({tx_enable, rx_enable, rts_n, tx_grant}), 4'b0010);
            end
        end while (hd_state != 2'd0 && n < 30);
        check($sformatf("guard%0d_turnaround", g), n, g + 2);
        check($sformatf("guard%0d_cycles", g), gc, g + 1);
    endtask

    function automatic bit cts_at(int k);
        return k < 0 ? 1'b1 : cts_h[k];
    endfunction

    // Readiness after edge t: decided by the most recent level that hit a watermark.
    function automatic bit ready_after(int t);
        for (int u = t - 1; u >= 0; u--) begin
            if (int'(lvl_h[u]) >= HI) return 1'b0;
            if (int'(lvl_h[u]) <= LO) return 1'b1;
        end
        return 1'b1;
    endfunction

    task automatic drive(input int t);
        cts_h[t] = (t == 0) ? 1'($urandom_range(0, 1)) :
                   ($urandom_range(0, 3) == 0) ? ~cts_h[t-1] : cts_h[t-1];
        req_h[t] = 1'($urandom_range(0, 1));
        fc_h[t]  = $urandom_range(0, 7) != 0;
        lvl_h[t] = 5'($urandom_range(0, 16));
        cts_n    = cts_h[t];
        tx_req   = req_h[t];
        fc_en    = fc_h[t];
        rx_level = lvl_h[t];
    endtask

    initial begin
        tv[0]  = '{FULLDUPLEX, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  6'b110100};
        tv[1]  = '{FULLDUPLEX, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0,  6'b110000};
        tv[2]  = '{FULLDUPLEX, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 6'b110100};
        tv[3]  = '{FULLDUPLEX, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 6'b111000};
        tv[4]  = '{SIMPLEX,    1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 6'b101100};
        tv[5]  = '{SIMPLEX,    1'b1, 1'b1, 1'b1, 1'b1, 5'd0,  6'b101000};
        tv[6]  = '{SIMPLEX,    1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 6'b011000};
        tv[7]  = '{SIMPLEX,    1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  6'b010000};
        tv[8]  = '{SIMPLEX,    1'b0, 1'b0, 1'b0, 1'b1, 5'd15, 6'b010000};
        tv[9]  = '{SIMPLEX,    1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  6'b010000};
        tv[10] = '{HALFDUPLEX, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  6'b001000};

        #1 rst = 1;
        #1 check("reset", int'(outs()), 6'b001000);
        tick;
        tick;
        rst = 0;

        for (int i = 0; i < 11; i++) begin
            cfg      = '{mode: tv[i].mode, master: tv[i].master};
            fc_en    = tv[i].fc;
            cts_n    = tv[i].cts;
            tx_req   = tv[i].req;
            rx_level = tv[i].lvl;
            repeat (5) tick;
            check($sformatf("vec%0d", i), int'(outs()), int'(tv[i].exp));
        end

        // CTS latency and RTS hysteresis in full duplex
        cfg = '{mode: FULLDUPLEX, master: 1'b0};
        fc_en = 1; cts_n = 1; tx_req = 1; rx_level = 0;
        repeat (5) tick;
        check("cts_idle", int'(tx_grant), 0);
        cts_n = 0;
        for (int k = 1; k <= 3; k++) begin
            tick;
            check($sformatf("cts_lat%0d", k), int'(tx_grant), int'(k == 3));
        end
        for (int lv = 0; lv <= 12; lv++) begin
            rx_level = 5'(lv);
            tick;
            check($sformatf("ramp_up%0d", lv), int'(rts_n), 0);
        end
        tick;
        check("rts_hi_wm", int'(rts_n), 1);
        for (int lv = 11; lv >= 5; lv--) begin
            rx_level = 5'(lv);
            tick;
            check($sformatf("ramp_dn%0d", lv), int'(rts_n), 1);
        end
        rx_level = 5'd4;
        tick;
        check("rts_lo_wm_d1", int'(rts_n), 1);
        tick;
        check("rts_lo_wm_d2", int'(rts_n), 0);

        // Half-duplex collisions: CTS and request reach the arbiter together
        cfg = '{mode: HALFDUPLEX, master: 1'b0};
        tx_req = 0; cts_n = 1; rx_level = 0; guard = 0;
        repeat (4) tick;
        cts_n = 0;
        tick;
        tick;
        tx_req = 1;
        check("hd_pre", int'(hd_state), 0);
        tick;
        check("hd_slave", int'(outs()), 6'b010010);
        tx_req = 0; cts_n = 1;
        wait_state("hd_rx_release", 2'd0, 20);
        cfg.master = 1'b1;
        cts_n = 0;
        tick;
        tick;
        tx_req = 1;
        tick;
        check("hd_master", int'(outs()), 6'b100101);

        // Turnaround guard
        cts_n = 1;
        repeat (3) tick;
        guard_run(5);
        tx_req = 1;
        tick;
        check("hd_tx_again", int'(hd_state), 1);
        guard_run(0);

        // Mode change mid-frame
        tx_req = 1;
        tick;
        check("hd_tx_mc", int'(hd_state), 1);
        cfg.mode = FULLDUPLEX;
        tick;
        check("mode_change", int'(hd_state), 3);

        // Asynchronous reset mid-reception
        cfg = '{mode: HALFDUPLEX, master: 1'b0};
        tx_req = 0;
        wait_state("hd_settle", 2'd0, 40);
        cts_n = 0;
        repeat (3) tick;
        check("hd_rx", int'(hd_state), 2);
        #2 rst = 1;
        #1 check("rst_async", int'(outs()), 6'b001000);
        #3;

        // Randomized full-duplex run
        cfg = '{mode: FULLDUPLEX, master: 1'b0};
        tx_busy = 0; rx_busy = 0;
        drive(0);
        #1 rst = 0;
        for (int t = 1; t < N; t++) begin
            tick;
            check($sformatf("rand%0d", t), int'(outs()),
                  int'({1'b1, 1'b1, fc_h[t-1] & ~ready_after(t - 1),
                        req_h[t-1] & (~cts_at(t - 1 - S) | ~fc_h[t-1]), 2'b00}));
            drive(t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_hw_flow_ctrl.md
# uart_hw_flow_ctrl

Parametrised RTS/CTS hardware flow controller for the UART IP, sitting between the pins and the TX/RX engines. It adds an internal CTS synchroniser, watermark-driven RTS with hysteresis from the RX FIFO occupancy, and a half-duplex line arbiter with configurable master priority and turnaround guard time. Full-duplex and simplex modes are also supported. Mode selection comes from the shared `Config_t`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: CTS synchroniser depth; legal values are ≥2.
- `FIFO_AW`, default 4: RX FIFO address width. The level width is `FIFO_AW+1`.
- `GUARD_W`, default 8: width of the turnaround guard counter.

Ports:
- `tck`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `cts_n_i`  in  1  CTS pin, asynchronous, active-low.
- `rts_n_o`  out  1  RTS pin, registered, active-low.
- `tx_req_i`  in  1  TX has a frame pending.
- `tx_busy_i`  in  1  TX is shifting a frame.
- `tx_grant_o`  out  1  TX may start a frame. Registered.
- `tx_enable_o`  out  1  TX port enable. Registered.
- `rx_busy_i`  in  1  RX is receiving a frame.
- `rx_level_i`  in  FIFO_AW+1  RX FIFO occupancy.
- `rx_enable_o`  out  1  RX port enable. Registered.
- `cfg_fc_en_i`  in  1  enables RTS/CTS handshaking.
- `cfg_hi_wm_i`  in  FIFO_AW+1  RTS deassert watermark.
- `cfg_lo_wm_i`  in  FIFO_AW+1  RTS reassert watermark.
- `cfg_guard_i`  in  GUARD_W  turnaround cycles.
- `uart_config_i`  in  Config_t  mode (FULLDUPLEX/HALFDUPLEX/SIMPLEX) and `master`.
- `hd_state_o`  out  2  current half-duplex state, for status.

## Operation
- **CTS synchroniser.** `cts_s` is `cts_n_i` passed through `SYNC_STAGES` flops, each reset to 1.
- **RX-ready hysteresis flag `rx_rdy`.**
  - Reset value is 1.
  - Clears when `rx_level_i >= cfg_hi_wm_i`.
  - Else sets when `rx_level_i <= cfg_lo_wm_i`.
  - Else holds its value.
  - Clearing has priority, so overlapping watermarks resolve to not-ready.
- **FULLDUPLEX.**
  - `tx_enable_o = rx_enable_o = 1`.
  - `rts_n_o = ~rx_rdy`.
  - `tx_grant_o = tx_req_i & (~cts_s | ~cfg_fc_en_i)`.
  - With `cfg_fc_en_i=0`, `rts_n_o` is 0.
  - The grant only gates the start of a frame. CTS deassertion mid-frame never aborts a frame in progress.
- **SIMPLEX, `master=1`.** TX only: `tx_enable_o=1`, `rx_enable_o=0`, `rts_n_o=1`; the grant follows the full-duplex rule.
- **SIMPLEX, `master=0`.** RX only: `tx_enable_o=0`, `tx_grant_o=0`, and `rts_n_o` follows the full-duplex rule.
- **HALFDUPLEX FSM.** States are HD_IDLE, HD_TX, HD_RX and HD_GUARD.
  - **HD_IDLE.** All enables are 0, `rts_n_o=1`.
    - Goes to HD_RX if `~cts_s` and not (`tx_req_i & master`).
    - Else goes to HD_TX if `tx_req_i`.
    - On a simultaneous request: the remote wins when `master=0`, the local side wins when `master=1`.
  - **HD_TX.** `tx_enable_o=1`, `rts_n_o=0`.
    - `tx_grant_o = tx_req_i & (~cts_s | ~cfg_fc_en_i)`.
    - Exits to HD_GUARD when `~tx_req_i & ~tx_busy_i`.
  - **HD_RX.** `rx_enable_o=1`, `rts_n_o = ~rx_rdy`.
    - Exits to HD_GUARD when `cts_s & ~rx_busy_i`.
  - **HD_GUARD.**
    - On entry the counter loads `cfg_guard_i`.
    - While in the state, enables are 0 and `rts_n_o=1`.
    - The counter decrements each cycle and the FSM returns to HD_IDLE in the cycle after the counter reads 0.
    - With `cfg_guard_i=0`, the FSM spends exactly 1 cycle in HD_GUARD.
- **Mode change.** Any change to `uart_config_i.mode` while the FSM is not in HD_IDLE forces HD_GUARD. Outside HALFDUPLEX the FSM is held in HD_IDLE.

## Timing
- **Reset values.**
  - `rts_n_o=1`, `tx_grant_o=0`, `tx_enable_o=0`, `rx_enable_o=0`.
  - `hd_state_o=HD_IDLE`, `rx_rdy=1`, guard counter 0.
  - Reset takes effect immediately and asynchronously, including mid-frame.
- **Latencies.**
  - `cts_n_i` edge to `tx_grant_o`: `SYNC_STAGES+1` cycles.
  - `rx_level_i` crossing a watermark to `rts_n_o`: 2 cycles (flag register plus output register).
  - FSM transition to the new enables and `rts_n_o`: 1 cycle.
  - Half-duplex turnaround, from the busy/req condition to HD_IDLE: `cfg_guard_i+2` cycles.

## Structure
- **`uart_defs` additions.**
  - Add `HdState_t` with encoding HD_IDLE=0, HD_TX=1, HD_RX=2, HD_GUARD=3.
  - Reuse `Config_t` and the mode constants already defined there.
- **Sub-module `uart_sync`.** A generic N-stage bit synchroniser with parameters `STAGES` and `RST_VAL`. It is instantiated here for CTS and is reusable for the RX pin.

## Test plan
1. **Full duplex, CTS and watermarks.**
   - Stimulus: FULLDUPLEX, fc_en=1, `SYNC_STAGES=2`, `tx_req_i=1`, CTS falls at cycle 10.
   - Required: `tx_grant_o` rises at cycle 13.
   - Continue with hi_wm=12, lo_wm=4 and `rx_level_i` stepping 0→12. Required: `rts_n_o` goes high 2 cycles after the level reaches 12.
   - Then step the level down through 11..5. Required: `rts_n_o` stays high. At level 4 it goes low.
2. **Half-duplex collisions.**
   - Stimulus: HALFDUPLEX, `master=0`, CTS low and `tx_req_i=1` in the same cycle. Required: HD_RX, `rx_enable_o=1`, `tx_grant_o=0`.
   - Repeat with `master=1`. Required: HD_TX, `rts_n_o=0`.
3. **Guard time.**
   - Stimulus: in HD_TX, drop req and busy with guard=5. Required: 7 cycles from the drop to HD_IDLE, with enables 0 throughout HD_GUARD.
   - Repeat with guard=0. Required: exactly 1 HD_GUARD cycle.
4. **Simplex slave with fc_en=0.**
   - Required: `tx_enable_o=0`, `rx_enable_o=1`, `rts_n_o=0` regardless of `rx_level_i`.
5. **Disruptions.**
   - Stimulus: assert `rst` mid-HD_RX. Required: all outputs return to their reset values without waiting for a clock edge.
   - Stimulus: change mode mid-HD_TX. Required: the FSM enters HD_GUARD on the next cycle.
